// File: rtl/change_dispenser_if.sv
// Change-dispenser bus: request handshake, hopper eject/ack, refill, and status.
interface change_dispenser_if;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_amount;
  logic       eject_valid;
  logic [1:0] eject_coin;
  logic       eject_ack;
  logic       refill_valid;
  logic [1:0] refill_coin;
  logic [3:0] refill_qty;
  logic       done;
  logic [5:0] paid;
  logic [5:0] shortfall;
  logic       busy;
  logic       fault;
  logic       fault_clr;
  logic [2:0] inv_empty;

  modport master (
    output req_valid, req_amount, eject_ack, refill_valid, refill_coin, refill_qty, fault_clr,
    input  req_ready, eject_valid, eject_coin, done, paid, shortfall, busy, fault, inv_empty
  );
  modport slave (
    input  req_valid, req_amount, eject_ack, refill_valid, refill_coin, refill_qty, fault_clr,
    output req_ready, eject_valid, eject_coin, done, paid, shortfall, busy, fault, inv_empty
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser: pays an amount in nickels from quarter/dime/nickel
// inventories, one hopper handshake per coin, with an eject timeout fault.
module change_dispenser #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int INV_INIT       = 20
) (
  input logic clk,
  input logic rst_n,
  change_dispenser_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SELECT, EJECT, DONE, FAULT} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t         state, state_nx;
  logic [TW-1:0]  tmo_cnt;
  logic [5:0]     remaining, paid_q, short_q, coin_val;
  logic [1:0]     coin_q, pick;
  logic [7:0]     n_cnt, d_cnt, q_cnt;
  logic           accept, ack_hit, tmo_hit;

  assign accept  = (state == IDLE) && bus.req_valid;
  assign ack_hit = (state == EJECT) && bus.eject_ack;
  assign tmo_hit = (state == EJECT) && !bus.eject_ack && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    pick = 2'b00;
    if (remaining >= 6'd5 && q_cnt != 8'd0)      pick = 2'b11;
    else if (remaining >= 6'd2 && d_cnt != 8'd0) pick = 2'b10;
    else if (n_cnt != 8'd0)                      pick = 2'b01;
  end

  always_comb begin
    case (coin_q)
      2'b11:   coin_val = 6'd5;
      2'b10:   coin_val = 6'd2;
      2'b01:   coin_val = 6'd1;
      default: coin_val = 6'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SELECT;
      SELECT:  if (remaining == 6'd0 || pick == 2'b00) state_nx = DONE;
               else                                    state_nx = EJECT;
      EJECT:   if (ack_hit)      state_nx = SELECT;
               else if (tmo_hit) state_nx = FAULT;
      DONE:    state_nx = IDLE;
      FAULT:   if (bus.fault_clr) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Refill and ack decrement may hit the same coin in one cycle; the decrement
  // only happens on a coin that was picked with a non-zero count, so no underflow.
  function automatic logic [7:0] inv_next(input logic [7:0] cnt, input logic add,
                                          input logic [3:0] qty, input logic dec);
    logic [9:0] s;
    s = {2'b00, cnt} + {6'd0, (add ? qty : 4'd0)} - {9'd0, dec};
    return (s > 10'd255) ? 8'hFF : s[7:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      paid_q    <= '0;
      short_q   <= '0;
      coin_q    <= '0;
      tmo_cnt   <= '0;
      n_cnt     <= 8'(INV_INIT);
      d_cnt     <= 8'(INV_INIT);
      q_cnt     <= 8'(INV_INIT);
    end else begin
      n_cnt <= inv_next(n_cnt, bus.refill_valid && bus.refill_coin == 2'b01, bus.refill_qty,
                        ack_hit && coin_q == 2'b01);
      d_cnt <= inv_next(d_cnt, bus.refill_valid && bus.refill_coin == 2'b10, bus.refill_qty,
                        ack_hit && coin_q == 2'b10);
      q_cnt <= inv_next(q_cnt, bus.refill_valid && bus.refill_coin == 2'b11, bus.refill_qty,
                        ack_hit && coin_q == 2'b11);
      case (state)
        IDLE: if (accept) begin
          remaining <= bus.req_amount;
          paid_q    <= '0;
          short_q   <= '0;
        end
        SELECT: begin
          coin_q  <= pick;
          tmo_cnt <= '0;
          if (remaining != 6'd0 && pick == 2'b00) short_q <= remaining;
        end
        EJECT: begin
          if (ack_hit) begin
            remaining <= remaining - coin_val;
            paid_q    <= paid_q + coin_val;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.fault       = (state == FAULT);
  assign bus.eject_valid = (state == EJECT);
  assign bus.eject_coin  = (state == EJECT) ? coin_q : 2'b00;
  assign bus.paid        = paid_q;
  assign bus.shortfall   = short_q;
  assign bus.inv_empty   = {q_cnt == 8'd0, d_cnt == 8'd0, n_cnt == 8'd0};
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning cycles eject_valid may wait for eject_ack before a fault.
REQ-002 SHALL have parameter INV_INIT, default 20, meaning the reset count of each coin-type inventory.
REQ-003 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have req_valid / req_ready  input / output  1 / 1  change-request handshake.
REQ-006 SHALL have req_amount  input  6  change to pay, in nickels (0-63).
REQ-007 SHALL have eject_valid  output  1  coin-eject request to the hopper.
REQ-008 SHALL have eject_coin  output  2  coin to eject: 01 nickel, 10 dime, 11 quarter; 00 when idle.
REQ-009 SHALL have eject_ack  input  1  hopper confirms one coin ejected.
REQ-010 SHALL have refill_valid, refill_coin, refill_qty  input  1, 2, 4  inventory top-up.
REQ-011 SHALL have done, paid, shortfall  output  1, 6, 6  completion pulse, nickels paid, nickels unpaid.
REQ-012 SHALL have busy, fault, fault_clr  output, output, input  1, 1, 1  status, latched timeout flag, fault clear.
REQ-013 SHALL have inv_empty  output  3  bit0 nickel, bit1 dime, bit2 quarter; count is zero.

Function
REQ-014 SHALL implement the states IDLE, SELECT, EJECT, DONE and FAULT.
REQ-015 SHALL drive req_ready=1 only in IDLE, and req_valid&&req_ready SHALL latch remaining=req_amount, clear paid and enter SELECT.
REQ-016 SHALL, in SELECT with remaining==0, enter DONE.
REQ-017 SHALL, in SELECT, pick greedily: quarter if remaining>=5 and q_cnt>0; else dime if remaining>=2 and d_cnt>0; else nickel if n_cnt>0; then enter EJECT.
REQ-018 SHALL, in SELECT with remaining>0 and no eligible coin, enter DONE with shortfall=remaining.
REQ-019 SHALL, in EJECT, hold eject_valid=1 and eject_coin stable until eject_ack is sampled high.
REQ-020 SHALL, on eject_ack in EJECT, subtract the coin value (1/2/5) from remaining, add it to paid, decrement that inventory count, and return to SELECT.
REQ-021 SHALL ignore eject_ack outside EJECT.
REQ-022 SHALL count EJECT cycles without ack, restarting the count on each EJECT entry.
REQ-023 SHALL, when that count reaches TIMEOUT_CYCLES, enter FAULT with eject_valid=0, fault=1 and no inventory change.
REQ-024 SHALL pulse done for exactly one cycle in DONE, with paid and shortfall valid that cycle, then return to IDLE.
REQ-025 SHALL hold paid and shortfall until the next request is accepted.
REQ-026 SHALL stay in FAULT, with req_ready=0 and busy=1, until fault_clr=1.
REQ-027 SHALL, on fault_clr in FAULT, go to IDLE, clear fault and discard the pending request without a done pulse.
REQ-028 SHALL drive busy=1 in every state except IDLE.
REQ-029 SHALL hold each inventory count as 8-bit, and refill_valid SHALL add refill_qty to the count selected by refill_coin in any state.
REQ-030 SHALL saturate each inventory count at 255.
REQ-031 SHALL ignore refills with refill_coin=00.
REQ-032 SHALL apply both a refill and an ack decrement of the same coin in one cycle (net +qty-1, saturated).
REQ-033 SHALL derive inv_empty combinationally from the counts.
REQ-034 SHALL give a request with req_amount=0 done=1 exactly 2 cycles after acceptance, with paid=0 and shortfall=0.
REQ-035 SHALL keep remaining, paid and shortfall 6-bit; paid+shortfall SHALL equal the accepted req_amount at done.

Reset
REQ-036 SHALL, on rst_n=0 and asynchronously, force IDLE; remaining, paid, shortfall and the timeout counter to 0; done, eject_valid, fault and busy to 0; eject_coin to 00; and all inventories to INV_INIT.
REQ-037 SHALL, on reset assertion mid-EJECT, drop eject_valid immediately without waiting for a clock edge.
REQ-038 SHALL enter no EJECT after reset release until a new request is accepted.

Verification
REQ-039 SHALL cover: all inventories at 20, req_amount=7, ack 1 cycle after each eject_valid -> quarter then dime; done with paid=7, shortfall=0; q_cnt=19, d_cnt=19.
REQ-040 SHALL cover: q_cnt=0 via reset with INV_INIT=0 then refill of dimes and nickels, req_amount=10 -> five dimes; paid=10.
REQ-041 SHALL cover: n_cnt=0, req_amount=3 -> one dime; done with paid=2, shortfall=1.
REQ-042 SHALL cover: req_amount=5 with eject_ack held low -> fault=1 after 16 EJECT cycles; q_cnt unchanged; fault_clr -> IDLE with no done pulse.
REQ-043 SHALL cover: refill of quarters, qty=3, in the same cycle as a quarter ack with q_cnt=254 -> q_cnt=255.
REQ-044 SHALL cover: rst_n pulled low mid-EJECT -> eject_valid=0 immediately; inventories=INV_INIT after release; req_amount=0 -> done exactly 2 cycles after acceptance.
